can_tx_prio_queue: RTL

Transmit-side priority queue between the MOPSHUB bus-side request logic and a CAN controller's transmit port. Buffers up to DEPTH pending CAN frames and offers the highest-priority one to the controller. Priority is lowest 11-bit ID first, then lowest SDO command byte, then lowest slot index. A request with ID 0x000 (NMT) flushes all pending frames. Frames that are not yet accepted can be pre-empted, and aborted frames are re-queued.

---
 rtl/can_tx_prio_queue_pkg.sv | 36 +++
 rtl/can_tx_prio_queue_if.sv | 40 ++++
 rtl/can_tx_prio_select.sv | 35 +++
 rtl/can_tx_prio_queue.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/can_tx_prio_queue_pkg.sv
// Shared types for the CAN transmit priority queue.
// Frame widths, slot layout, FSM states and the priority key.
package can_tx_pkg;

  localparam int ID_W   = 11;
  localparam int CMD_W  = 8;
  localparam int DATA_W = 64;
  localparam int DLC_W  = 4;
  localparam int KEY_W  = ID_W + CMD_W;

  localparam logic [ID_W-1:0] NMT_ID = 11'h000;

  typedef struct packed {
    logic              valid;
    logic              inflight;
    logic [ID_W-1:0]   id;
    logic [CMD_W-1:0]  sdocmd;
    logic [DATA_W-1:0] data;
    logic [DLC_W-1:0]  dlc;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OFFER,
    BUSY
  } state_e;

  function automatic logic [KEY_W-1:0] prio_key(
    input logic [ID_W-1:0]  id,
    input logic [CMD_W-1:0] cmd
  );
    return {id, cmd};
  endfunction

endpackage

// File: rtl/can_tx_prio_queue_if.sv
// Request and transmit handshakes between bus logic,
// the priority queue and the CAN controller.
interface can_tx_prio_queue_if;
  import can_tx_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_id;
  logic [CMD_W-1:0]  req_sdocmd;
  logic [DATA_W-1:0] req_data;
  logic [DLC_W-1:0]  req_dlc;

  logic              tx_valid;
  logic              tx_ready;
  logic [ID_W-1:0]   tx_id;
  logic [CMD_W-1:0]  tx_sdocmd;
  logic [DATA_W-1:0] tx_data;
  logic [DLC_W-1:0]  tx_dlc;
  logic              tx_done;
  logic              tx_abort;

  modport slave (
    input  req_valid, req_id, req_sdocmd,
    input  req_data, req_dlc,
    output req_ready,
    output tx_valid, tx_id, tx_sdocmd,
    output tx_data, tx_dlc,
    input  tx_ready, tx_done, tx_abort
  );

  modport master (
    output req_valid, req_id, req_sdocmd,
    output req_data, req_dlc,
    input  req_ready,
    input  tx_valid, tx_id, tx_sdocmd,
    input  tx_data, tx_dlc,
    output tx_ready, tx_done, tx_abort
  );

endinterface

// File: rtl/can_tx_prio_select.sv
// Combinational min-finder over the queue slots.
// Key is {id, sdocmd}; ties go to the lowest slot index.
module can_tx_prio_select
  import can_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  slot_t [DEPTH-1:0] slots_i,
  output logic  [IW-1:0]    win_idx_o,
  output logic              any_pending_o
);

  logic [KEY_W-1:0] best;
  logic [KEY_W-1:0] key;

  always_comb begin
    win_idx_o     = '0;
    any_pending_o = 1'b0;
    best          = '1;
    key           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      key = prio_key(slots_i[i].id, slots_i[i].sdocmd);
      if (slots_i[i].valid && !slots_i[i].inflight) begin
        // strict compare keeps the lower index on ties
        if (!any_pending_o || key < best) begin
          best          = key;
          win_idx_o     = IW'(i);
          any_pending_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/can_tx_prio_queue.sv
// Transmit priority queue feeding a CAN controller, with
// pre-emption of unaccepted offers, abort re-queue and NMT flush.
module can_tx_prio_queue
  import can_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  can_tx_prio_queue_if.slave bus,
  output logic [3:0]         q_count,
  output logic               q_full,
  output logic               q_empty,
  output logic               nmt_flush
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  slot_t [DEPTH-1:0] slots_q, slots_d;
  state_e            state_q;
  logic [IW-1:0]     cur_q;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     wr_idx;
  logic              any_pend;
  logic              pend_d;
  logic [3:0]        count_q, count_d;
  logic              full_q, empty_q, nmt_q;

  logic              tx_valid_q;
  logic [ID_W-1:0]   tx_id_q;
  logic [CMD_W-1:0]  tx_cmd_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [DLC_W-1:0]  tx_dlc_q;

  logic req_acc, is_nmt, hs;
  logic done_ev, abort_ev, preempt;

  can_tx_prio_select #(
    .DEPTH(DEPTH)
  ) u_sel (
    .slots_i      (slots_q),
    .win_idx_o    (win_idx),
    .any_pending_o(any_pend)
  );

  assign req_acc  = bus.req_valid && !full_q;
  assign is_nmt   = req_acc && (bus.req_id == NMT_ID);
  assign hs       = (state_q == OFFER) && bus.tx_ready;
  assign done_ev  = (state_q == BUSY) && bus.tx_done;
  assign abort_ev = (state_q == BUSY) && bus.tx_abort
                    && !bus.tx_done;
  assign preempt  = (state_q == OFFER) && !bus.tx_ready
                    && req_acc
                    && (prio_key(bus.req_id, bus.req_sdocmd)
                        < prio_key(tx_id_q, tx_cmd_q));

  always_comb begin
    slots_d = slots_q;
    wr_idx  = '0;
    pend_d  = 1'b0;
    count_d = '0;
    if (hs) slots_d[cur_q].inflight = 1'b1;
    // flush sees the handshake but not a same-cycle abort
    if (is_nmt) begin
      for (int i = 0; i < DEPTH; i++)
        if (!slots_d[i].inflight) slots_d[i] = '0;
    end
    if (done_ev) slots_d[cur_q] = '0;
    if (abort_ev) slots_d[cur_q].inflight = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!slots_d[i].valid) wr_idx = IW'(i);
    if (req_acc) begin
      slots_d[wr_idx].valid    = 1'b1;
      slots_d[wr_idx].inflight = 1'b0;
      slots_d[wr_idx].id       = bus.req_id;
      slots_d[wr_idx].sdocmd   = bus.req_sdocmd;
      slots_d[wr_idx].data     = bus.req_data;
      slots_d[wr_idx].dlc      = bus.req_dlc;
    end
    for (int i = 0; i < DEPTH; i++) begin
      pend_d  = pend_d
                | (slots_d[i].valid & ~slots_d[i].inflight);
      count_d = count_d + 4'(slots_d[i].valid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots_q    <= '0;
      state_q    <= IDLE;
      cur_q      <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      nmt_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_id_q    <= '0;
      tx_cmd_q   <= '0;
      tx_data_q  <= '0;
      tx_dlc_q   <= '0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
      full_q  <= (count_d == 4'(DEPTH));
      empty_q <= (count_d == 4'd0);
      nmt_q   <= is_nmt;
      unique case (state_q)
        IDLE: begin
          if (any_pend) state_q <= SELECT;
        end
        SELECT: begin
          // a new arrival may beat the current winner: re-evaluate
          if (!req_acc) begin
            if (any_pend) begin
              cur_q      <= win_idx;
              tx_id_q    <= slots_q[win_idx].id;
              tx_cmd_q   <= slots_q[win_idx].sdocmd;
              tx_data_q  <= slots_q[win_idx].data;
              tx_dlc_q   <= slots_q[win_idx].dlc;
              tx_valid_q <= 1'b1;
              state_q    <= OFFER;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        OFFER: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            state_q    <= BUSY;
          end else if (is_nmt || preempt) begin
            tx_valid_q <= 1'b0;
            state_q    <= SELECT;
          end
        end
        BUSY: begin
          if (done_ev || abort_ev)
            state_q <= pend_d ? SELECT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = !full_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_id     = tx_id_q;
  assign bus.tx_sdocmd = tx_cmd_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_dlc    = tx_dlc_q;

  assign q_count   = count_q;
  assign q_full    = full_q;
  assign q_empty   = empty_q;
  assign nmt_flush = nmt_q;

endmodule
